// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. It sequences one instruction
// at a time through FETCH, DECODE, EXEC, MEM and WB. Outputs are decoded from
// the registered state; the handshake strobes are also qualified by the
// same-cycle ready or branch result.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        imem_ready,
  output logic        imem_req,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        alu_out_we,
  output logic        imm_en,
  output logic [1:0]  opa_sel,
  output logic        alu_func_dec,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Last count value before expiry: a wait in this cycle without ready traps.
  localparam logic [7:0] WD_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state;
  logic [7:0] wd_cnt;

  logic is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc;
  logic is_legal;

  // Opcode class decode from the instruction register.
  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_l     = (opcode == OP_L);
    is_s     = (opcode == OP_S);
    is_b     = (opcode == OP_B);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_lui   = (opcode == OP_LUI);
    is_auipc = (opcode == OP_AUIPC);
    is_legal = is_r | is_i | is_l | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;
  end

  // Output decode of the current state.
  always_comb begin
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_out_we   = 1'b0;
    imm_en       = 1'b0;
    opa_sel      = 2'b00;
    alu_func_dec = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        alu_out_we   = 1'b1;
        imm_en       = ~is_r;
        if (is_auipc || is_jal || is_b) opa_sel = 2'b01;
        else if (is_lui)                opa_sel = 2'b10;
        alu_func_dec = is_r | is_i;
        if (is_b) begin
          pc_we  = 1'b1;
          pc_sel = br_taken;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_s;
        if (is_s && dmem_ready) pc_we = 1'b1;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (is_l)                 wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        pc_sel = is_jal | is_jalr;
      end
      default: ;
    endcase
  end

  // State sequencing, handshake watchdog, sticky traps and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wd_cnt  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      retired <= '0;
    end else begin
      if (pc_we) retired <= retired + 32'd1;
      // Watchdog clears unless a wait cycle below increments it.
      wd_cnt <= '0;
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wd_cnt == WD_LAST) begin
            state   <= S_TRAP;
            bus_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_b)              state <= S_FETCH;
          else if (is_l || is_s) state <= S_MEM;
          else                   state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            state <= is_s ? S_FETCH : S_WB;
          end else if (wd_cnt == WD_LAST) begin
            state   <= S_TRAP;
            bus_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a short watchdog limit.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        imem_ready;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        alu_out_we;
  logic        imm_en;
  logic [1:0]  opa_sel;
  logic        alu_func_dec;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic        pc_sel;
  logic        illegal;
  logic        bus_err;
  logic [31:0] retired;

  logic [15:0] ctl;
  int checks;
  int failures;

  assign ctl = {imem_req, ir_we, dmem_req, dmem_we, alu_out_we, imm_en, opa_sel,
                alu_func_dec, reg_we, wb_sel, pc_we, pc_sel, illegal, bus_err};

  multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .imem_ready(imem_ready), .imem_req(imem_req),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .alu_out_we(alu_out_we), .imm_en(imm_en), .opa_sel(opa_sel),
    .alu_func_dec(alu_func_dec), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal), .bus_err(bus_err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs for the new cycle are applied 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // From FETCH: zero-wait fetch of op, one DECODE cycle, arrive in EXEC.
  task automatic fetch_decode(input logic [6:0] op);
    imem_ready = 1'b1;
    opcode     = op;
    #1;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_ir_we", {31'd0, ir_we}, 32'd1);
    tick();
    imem_ready = 1'b0;
    #1;
    chk("decode_quiet", {16'd0, ctl}, 32'd0);
    tick();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    opcode     = 7'd0;
    br_taken   = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ctl", {16'd0, ctl}, 32'd0);
    chk("reset_retired", retired, 32'd0);

    // Release: one IDLE cycle with everything low, then FETCH.
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", {16'd0, ctl}, 32'd0);
    tick();

    // R-type
    fetch_decode(7'b0110011);
    #1;
    chk("r_exec_alu_we", {31'd0, alu_out_we}, 32'd1);
    chk("r_exec_imm_en", {31'd0, imm_en}, 32'd0);
    chk("r_exec_func", {31'd0, alu_func_dec}, 32'd1);
    chk("r_exec_opa", {30'd0, opa_sel}, 32'd0);
    chk("r_exec_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    #1;
    chk("r_wb_reg_we", {31'd0, reg_we}, 32'd1);
    chk("r_wb_sel", {30'd0, wb_sel}, 32'd0);
    chk("r_wb_pc_we", {31'd0, pc_we}, 32'd1);
    chk("r_wb_pc_sel", {31'd0, pc_sel}, 32'd0);
    tick();
    #1;
    chk("r_retired", retired, 32'd1);
    chk("r_next_fetch", {31'd0, imem_req}, 32'd1);

    // Load with dmem_ready arriving in the 4th MEM cycle (the limit cycle)
    fetch_decode(7'b0000011);
    #1;
    chk("l_exec_imm_en", {31'd0, imm_en}, 32'd1);
    chk("l_exec_func", {31'd0, alu_func_dec}, 32'd0);
    chk("l_exec_opa", {30'd0, opa_sel}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("l_mem_wait_req", {30'd0, dmem_req, dmem_we}, 32'b10);
      chk("l_mem_wait_pc_we", {31'd0, pc_we}, 32'd0);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("l_mem_ready_req", {30'd0, dmem_req, dmem_we}, 32'b10);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("l_wb_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("l_wb_sel", {30'd0, wb_sel}, 32'd1);
    chk("l_wb_we", {30'd0, reg_we, pc_we}, 32'b11);
    tick();
    #1;
    chk("l_retired", retired, 32'd2);
    chk("l_no_bus_err", {31'd0, bus_err}, 32'd0);
    chk("l_next_fetch", {31'd0, imem_req}, 32'd1);

    // Store, zero wait
    fetch_decode(7'b0100011);
    #1;
    chk("s_exec_imm_en", {31'd0, imm_en}, 32'd1);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("s_mem_req_we", {30'd0, dmem_req, dmem_we}, 32'b11);
    chk("s_mem_pc", {30'd0, pc_we, pc_sel}, 32'b10);
    chk("s_mem_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("s_retired", retired, 32'd3);
    chk("s_next_fetch", {31'd0, imem_req}, 32'd1);

    // Branch taken
    fetch_decode(7'b1100011);
    br_taken = 1'b1;
    #1;
    chk("bt_exec_pc", {30'd0, pc_we, pc_sel}, 32'b11);
    chk("bt_exec_opa", {30'd0, opa_sel}, 32'd1);
    chk("bt_exec_imm_en", {31'd0, imm_en}, 32'd1);
    chk("bt_exec_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    br_taken = 1'b0;
    #1;
    chk("bt_retired", retired, 32'd4);
    chk("bt_next_fetch", {31'd0, imem_req}, 32'd1);

    // Branch not taken
    fetch_decode(7'b1100011);
    #1;
    chk("bn_exec_pc", {30'd0, pc_we, pc_sel}, 32'b10);
    tick();
    #1;
    chk("bn_retired", retired, 32'd5);

    // JAL
    fetch_decode(7'b1101111);
    #1;
    chk("jal_exec_opa", {30'd0, opa_sel}, 32'd1);
    chk("jal_exec_func", {31'd0, alu_func_dec}, 32'd0);
    tick();
    #1;
    chk("jal_wb_sel", {30'd0, wb_sel}, 32'd2);
    chk("jal_wb_pc_sel", {31'd0, pc_sel}, 32'd1);
    tick();

    // LUI
    fetch_decode(7'b0110111);
    #1;
    chk("lui_exec_opa", {30'd0, opa_sel}, 32'd2);
    tick();
    #1;
    chk("lui_wb_sel_pc", {29'd0, wb_sel, pc_sel}, 32'd0);
    tick();

    // I-type
    fetch_decode(7'b0010011);
    #1;
    chk("i_exec_ctl", {29'd0, imm_en, alu_func_dec, alu_out_we}, 32'b111);
    tick();
    tick();
    #1;
    chk("i_retired", retired, 32'd8);

    // Watchdog boundary: ready arrives in the 4th FETCH cycle, no trap
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wd_edge_wait_req", {31'd0, imem_req}, 32'd1);
      tick();
    end
    fetch_decode(7'b0110011);
    #1;
    chk("wd_edge_exec", {31'd0, alu_out_we}, 32'd1);
    chk("wd_edge_no_err", {31'd0, bus_err}, 32'd0);
    tick();
    tick();
    #1;
    chk("wd_edge_retired", retired, 32'd9);

    // Watchdog expiry: 4 FETCH cycles without ready, then TRAP
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_trap_wait_req", {31'd0, imem_req}, 32'd1);
      tick();
    end
    #1;
    chk("wd_trap_ctl", {16'd0, ctl}, 32'd1);
    imem_ready = 1'b1;
    tick();
    #1;
    chk("wd_trap_hold", {16'd0, ctl}, 32'd1);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("wd_reset_ctl", {16'd0, ctl}, 32'd0);
    chk("wd_reset_retired", retired, 32'd0);
    tick();

    // Illegal opcode
    rst_n = 1'b1;
    tick();
    fetch_decode(7'b0000000);
    #1;
    chk("ill_trap_ctl", {16'd0, ctl}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      #1;
      chk("ill_ignore_ready", {16'd0, ctl}, 32'd2);
      tick();
    end
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ill_reset_clear", {31'd0, illegal}, 32'd0);
    tick();

    // Reset asserted during WB aborts the write-back at once
    rst_n = 1'b1;
    tick();
    fetch_decode(7'b0110011);
    tick();
    #1;
    chk("abort_wb_before", {30'd0, reg_we, pc_we}, 32'b11);
    rst_n = 1'b0;
    #1;
    chk("abort_wb_after", {30'd0, reg_we, pc_we}, 32'b00);
    tick();
    #1;
    chk("abort_retired", retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
